// File: rtl/m_pc.sv
// m_pc: program counter with ripple-increment, load, sync reset and optional return stack
//   Optional feature macro: PC_STACK_EN (adds the call/return stack and its ports)
//   i_clk         rising-edge clock
//   i_rst         asynchronous active-high reset (o_out=0, stack emptied, o_err=0)
//   i_sync_rst    synchronous CPU reset, highest priority
//   i_load        jump taken: load i_in
//   i_inc         advance to the next instruction
//   i_in          jump target
//   o_out         current PC
//   i_push        call (PC_STACK_EN): push o_out+1 while loading i_in
//   i_pop         return (PC_STACK_EN): pop top of stack into o_out
//   o_stack_empty registered empty status (PC_STACK_EN)
//   o_stack_full  registered full status (PC_STACK_EN)
//   o_err         sticky overflow/underflow flag (PC_STACK_EN)
module m_pc #(
    parameter int WIDTH = 16
`ifdef PC_STACK_EN
    , parameter int STACK_DEPTH = 4
`endif
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sync_rst,
    input  logic             i_load,
    input  logic             i_inc,
    input  logic [WIDTH-1:0] i_in,
    output logic [WIDTH-1:0] o_out
`ifdef PC_STACK_EN
    ,
    input  logic             i_push,
    input  logic             i_pop,
    output logic             o_stack_empty,
    output logic             o_stack_full,
    output logic             o_err
`endif
);
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] pc_next;

    // Half-adder ripple chain: carry-in of 1 at bit 0, wraps modulo 2^WIDTH.
    assign carry[0] = 1'b1;
    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_sum
        assign pc_inc[i] = o_out[i] ^ carry[i];
    end
    for (i = 0; i < WIDTH - 1; i++) begin : g_carry
        assign carry[i+1] = o_out[i] & carry[i];
    end

`ifdef PC_STACK_EN
    localparam int AW = $clog2(STACK_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL = PW'(STACK_DEPTH);

    logic [WIDTH-1:0] stack [STACK_DEPTH];
    logic [PW-1:0]    sp;
    logic [PW-1:0]    sp_next;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;
    logic             pop_ok;
    logic             push_ok;
    logic             err_next;

    assign empty   = sp == '0;
    assign full    = sp == FULL;
    // Sync reset suppresses both stack operations; pop outranks push.
    assign do_pop  = i_pop & ~i_sync_rst;
    assign do_push = i_push & i_load & ~i_pop & ~i_sync_rst;
    assign pop_ok  = do_pop & ~empty;
    assign push_ok = do_push & ~full;

    always_comb begin
        sp_next  = i_sync_rst ? '0 : pop_ok ? sp - 1'b1 : push_ok ? sp + 1'b1 : sp;
        err_next = ~i_sync_rst & (o_err | (do_pop & empty) | (do_push & full));
        pc_next  = i_sync_rst ? '0 :
                   do_pop     ? (empty ? o_out : stack[AW'(sp - 1'b1)]) :
                   i_load     ? i_in :
                   i_inc      ? pc_inc : o_out;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_out         <= '0;
            sp            <= '0;
            o_err         <= 1'b0;
            o_stack_empty <= 1'b1;
            o_stack_full  <= 1'b0;
        end else begin
            o_out         <= pc_next;
            sp            <= sp_next;
            o_err         <= err_next;
            o_stack_empty <= sp_next == '0;
            o_stack_full  <= sp_next == FULL;
        end
    end

    // Stack contents need no reset: the pointer alone defines validity.
    always_ff @(posedge i_clk) begin
        if (push_ok) stack[AW'(sp)] <= pc_inc;
    end
`else
    always_comb pc_next = i_sync_rst ? '0 : i_load ? i_in : i_inc ? pc_inc : o_out;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) o_out <= '0;
        else o_out <= pc_next;
    end
`endif
endmodule

// File: doc/m_pc.md
Name: m_pc

Overview:
- Program counter for the 16-bit CPU.
- Holds the address of the current instruction, drives the instruction-memory address, and updates once per clock by the CPU's control priority: reset, load (jump target from the A register), increment, or hold.
- Sits directly downstream of the ALU/jump-decision logic (whose gates include m_xor). It consumes the jump-taken flag and the target address and produces the next fetch address.
- The optional call/return stack provides subroutine support without a software stack.

Parameters:
- WIDTH, 16, address width in bits.
- STACK_DEPTH, 4, return-stack entries. Used only when PC_STACK_EN is defined. Must be ≥2 and a power of 2.

Ports:
- i_clk  input  1  system clock, rising-edge active.
- i_rst  input  1  asynchronous, active-high reset.
- i_sync_rst  input  1  synchronous CPU reset (the nand2tetris "reset" pin). Forces PC to 0 on the next edge.
- i_load  input  1  jump taken; load i_in.
- i_inc  input  1  advance to the next instruction.
- i_in  input  WIDTH  jump target address.
- o_out  output  WIDTH  current PC (instruction-memory address).
- i_push  input  1  call; only when PC_STACK_EN is defined.
- i_pop  input  1  return; only when PC_STACK_EN is defined.
- o_stack_empty  output  1  only when PC_STACK_EN is defined.
- o_stack_full  output  1  only when PC_STACK_EN is defined.
- o_err  output  1  sticky stack-fault flag; only when PC_STACK_EN is defined.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high; the clock and reset ports are i_clk and i_rst.
- i_rst asserted: o_out=0 immediately, without waiting for a clock edge. Stack pointer=0, o_stack_empty=1, o_stack_full=0, o_err=0. Stack contents are don't-care.
- Deassertion of i_rst is synchronised externally. The first active edge after deassertion is a normal update.
- Registered update on each rising i_clk, using the first matching rule:
  1. i_sync_rst → o_out=0. Stack pointer cleared; o_err cleared.
  2. i_pop (stack build) → o_out = top of stack; stack pointer decremented.
  3. i_load → o_out = i_in.
  4. i_inc → o_out = o_out+1, modulo 2^WIDTH.
  5. Otherwise hold.
- Latency: o_out reflects a request one cycle after the edge that samples it. There is no combinational path from any input to o_out.
- Wrap-around: 0xFFFF with i_inc → 0x0000. No flag is raised.
- i_load and i_inc together: load wins and the increment is discarded.
- i_sync_rst with any other inputs: reset wins. No push or pop takes effect.
- The incrementer is a ripple half-adder chain (XOR for sum, AND for carry). It must settle within one clock at the target frequency.

Optional Feature:
- Macro: PC_STACK_EN.
- Defined: adds the return stack (STACK_DEPTH × WIDTH registers plus a pointer) and the i_push, i_pop, o_stack_empty, o_stack_full and o_err ports.
  - Call (i_push): effective only together with i_load. Pushes o_out+1 (wrapped) and loads i_in in the same cycle. i_push without i_load is ignored.
  - Push when full: stack unchanged, o_err set to 1, and the load still happens.
  - Return (i_pop): pops to o_out.
  - Pop when empty: o_out holds, stack unchanged, o_err set to 1.
  - i_push and i_pop together: pop wins and the push is discarded. Pop has priority over i_load and i_inc.
  - o_err is sticky; it is cleared only by i_rst or i_sync_rst.
  - o_stack_empty and o_stack_full are registered status outputs, valid the cycle after the pointer changes.
- Undefined: none of the stack ports exist. Priority is i_sync_rst > i_load > i_inc > hold. Gate count is minimal.

Test Plan:
- Reset: assert i_rst mid-cycle while o_out=0x1234 → o_out=0x0000 immediately, before the next edge. Release, then i_inc for 3 cycles → 0x0001, 0x0002, 0x0003.
- Priority: o_out=0x0010; i_load=1, i_inc=1, i_in=0x0200 → 0x0200 next cycle. Then i_sync_rst=1, i_load=1 → 0x0000.
- Wrap: load 0xFFFF, then i_inc → 0x0000, then 0x0001. With no control asserted for 5 cycles → o_out holds 0x0001.
- Stack call/return (PC_STACK_EN): o_out=0x0020; i_push+i_load, i_in=0x0100 → 0x0100. i_inc twice → 0x0102. i_pop → 0x0021, o_stack_empty=1, o_err=0.
- Stack faults (PC_STACK_EN, STACK_DEPTH=4): 5 consecutive calls → o_stack_full=1 after the 4th; o_err=1 after the 5th, and o_out still equals the 5th target. Pop with an empty stack → o_out holds and o_err stays 1. i_sync_rst → o_err=0, o_stack_empty=1.
